// File: rtl/mips_cpu_multiplier.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU: one partial product per cycle,
// magnitudes multiplied, result negated when the operand signs differ.
module mips_cpu_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic [WIDTH-1:0] Product_hi,
  output logic [WIDTH-1:0] Product_lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;
  logic [2*WIDTH-1:0] signed_result;

  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    acc_hi_d      = acc_hi_q;
    acc_lo_d      = acc_lo_q;
    count_d       = count_q;
    neg_d         = neg_q;
    prod_hi_d     = prod_hi_q;
    prod_lo_d     = prod_lo_q;
    sum           = '0;
    result        = '0;
    signed_result = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Most-negative operand negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
          mcand_d  = (sign && Multiplicand[WIDTH-1]) ? -Multiplicand : Multiplicand;
          acc_lo_d = (sign && Multiplier[WIDTH-1])   ? -Multiplier   : Multiplier;
          acc_hi_d = '0;
          count_d  = '0;
          neg_d    = sign & (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        acc_hi_d = sum[WIDTH:1];
        acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          result        = {acc_hi_d, acc_lo_d};
          signed_result = neg_q ? -result : result;
          prod_hi_d     = signed_result[2*WIDTH-1:WIDTH];
          prod_lo_d     = signed_result[WIDTH-1:0];
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

  assign Product_hi = prod_hi_q;
  assign Product_lo = prod_lo_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: doc/mips_cpu_multiplier.md
Name: mips_cpu_multiplier

Overview:
- Iterative radix-2 shift-add multiplier; the multiply counterpart to the team's signed/unsigned divider, serving MULT/MULTU in the execute stage.
- Accepts two 32-bit operands on a start pulse and produces a 64-bit product as HI (Product_hi) and LO (Product_lo) after a fixed 33-cycle latency.
- Signed mode multiplies operand magnitudes, then negates the 64-bit result when the operand signs differ.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- start  input  1  operand-valid pulse; sampled only in IDLE
- sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start
- Multiplicand  input  32  operand A; sampled with start
- Multiplier  input  32  operand B; sampled with start
- Product_hi  output  32  upper product word (HI)
- Product_lo  output  32  lower product word (LO)
- busy  output  1  high in BUSY and DONE
- done  output  1  single-cycle result-valid pulse

Behaviour:
- Reset (reset=0, async): state=IDLE; Product_hi, Product_lo, internal accumulator and counter = 0; done=0; busy=0.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE: on an edge with start=1, latch the following and go to BUSY:
  - mcand = |Multiplicand| if sign else Multiplicand.
  - acc_lo = |Multiplier| if sign else Multiplier.
  - acc_hi = 0; count = 0.
  - neg = sign & (Multiplicand[31] ^ Multiplier[31]).
- Magnitude uses 32-bit two's-complement negate; 0x80000000 maps to 0x80000000 and is treated as unsigned 2^31 (correct magnitude).
- BUSY, each edge:
  - sum[32:0] = {1'b0, acc_hi} + (acc_lo[0] ? mcand : 0).
  - {acc_hi, acc_lo} = {sum, acc_lo} >> 1 (65-bit shift, carry preserved).
  - count++.
  - After the 32nd iteration (count reaches 32), go to DONE.
- Result registration occurs on the same edge as the 32nd iteration: {Product_hi, Product_lo} = neg ? -(64-bit result) : result.
- DONE: lasts one cycle; done=1, busy=1; then IDLE unconditionally.
- Latency: start sampled at edge E; done high during the cycle after edge E+32, deasserting at E+33. Next start accepted at edge E+33 or later.
- Product_hi/Product_lo hold their last value from DONE until the next result; they are not cleared by start.
- start asserted in BUSY or DONE: ignored, no queuing; operands are not re-sampled.
- Operand inputs may change freely after the start edge; only latched copies are used.
- Zero operand: full 32 iterations still run; result = 0; neg is forced irrelevant (-0 = 0).
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared, done not pulsed; the partial result is discarded.
- Reset release is synchronised externally; the block requires no extra deassertion logic.
- No overflow is possible: the 64-bit product is exact for all inputs in both modes.

Test Plan:
- Unsigned 3 x 5 (sign=0) -> done exactly 33 cycles after the start edge; HI=0x00000000, LO=0x0000000F; done high for exactly 1 cycle.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed -7 x 3 (0xFFFFFFF9, 0x00000003) -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; signed -1 x -1 -> HI=0, LO=1.
- Signed 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000; signed 0x80000000 x 1 -> HI=0xFFFFFFFF, LO=0x80000000.
- Start re-asserted with new operands while busy (12 x 12 then 2 x 2 at cycle 5) -> single done pulse, result 0x90 (144); second request ignored; busy high throughout.
- reset=0 at cycle 10 of a 7 x 9 multiply -> outputs 0 and state IDLE immediately (async, before next edge); no done pulse; a fresh start afterwards yields 63 on schedule.
